// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared types and sizes for the activation sequencer
package act_pkg;

  localparam int DATA_WIDTH    = 11;
  localparam int SA_LENGTH     = 256;
  localparam int ROW_CNT_WIDTH = 9;

  // Encoding is shared with the activation mux select, so values are fixed
  typedef enum logic [1:0] {
    ACT_PASS    = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2,
    ACT_TANH    = 2'd3
  } act_func_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } act_seq_state_e;

  typedef logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] act_row_t;

endpackage

// File: rtl/activation_sequencer_if.sv
// rtl/activation_sequencer_if.sv - job, row stream and activation-unit signals
interface activation_sequencer_if;
  import act_pkg::*;

  logic                     start;
  logic [1:0]               func;
  logic [ROW_CNT_WIDTH-1:0] num_rows;
  logic                     busy;
  logic                     done;
  logic                     in_valid;
  logic                     in_ready;
  act_row_t                 in_row;
  logic                     act_en;
  logic [1:0]               act_sel;
  act_row_t                 act_in;
  act_row_t                 act_out;
  logic                     out_valid;
  logic                     out_ready;
  act_row_t                 out_row;
  logic                     out_last;

  // Sequencer side
  modport slave (
    input  start, func, num_rows, in_valid, in_row, act_out, out_ready,
    output busy, done, in_ready, act_en, act_sel, act_in, out_valid, out_row, out_last
  );

  // Driver side (accumulator drain, activation mux, buffer write port)
  modport master (
    output start, func, num_rows, in_valid, in_row, act_out, out_ready,
    input  busy, done, in_ready, act_en, act_sel, act_in, out_valid, out_row, out_last
  );

endinterface

// File: rtl/act_pipe_reg.sv
// rtl/act_pipe_reg.sv - single-stage valid/ready row register with last flag
module act_pipe_reg
  import act_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  act_row_t load_row,
  input  logic     load_last,
  input  logic     out_ready,
  output logic     out_valid,
  output act_row_t out_row,
  output logic     out_last
);

  logic     valid_q, valid_d;
  logic     last_q, last_d;
  act_row_t row_q, row_d;

  // A load wins over a drain so a simultaneous in/out transfer keeps valid high
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    row_d   = row_q;
    if (load) begin
      valid_d = 1'b1;
      last_d  = load_last;
      row_d   = load_row;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Row register; data holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      row_q   <= row_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_row   = row_q;

endmodule

// File: rtl/activation_sequencer.sv
// rtl/activation_sequencer.sv - streams rows through the activation datapath
module activation_sequencer
  import act_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  activation_sequencer_if.slave bus
);

  localparam logic [ROW_CNT_WIDTH-1:0] CNT_ONE = {{(ROW_CNT_WIDTH-1){1'b0}}, 1'b1};

  act_seq_state_e           state_q, state_d;
  act_func_e                act_sel_q, act_sel_d;
  logic [ROW_CNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [ROW_CNT_WIDTH-1:0] count_q, count_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     act_en_q, act_en_d;

  logic                     out_valid;
  logic                     out_last;
  act_row_t                 out_row;
  logic                     in_ready;
  logic                     in_xfer;
  logic                     out_xfer;
  logic                     row_last;
  act_row_t                 result_row;

  assign in_ready   = (state_q == SEQ_RUN) && (!out_valid || bus.out_ready);
  assign in_xfer    = bus.in_valid && in_ready;
  assign out_xfer   = out_valid && bus.out_ready;
  assign row_last   = ((count_q + CNT_ONE) == num_rows_q);
  // Pass-through bypasses the activation mux entirely
  assign result_row = (act_sel_q == ACT_PASS) ? bus.in_row : bus.act_out;

  // Next-state, job latches, row counter and registered status outputs
  always_comb begin
    state_d    = state_q;
    act_sel_d  = act_sel_q;
    num_rows_d = num_rows_q;
    count_d    = count_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (bus.start) begin
          act_sel_d  = act_func_e'(bus.func);
          num_rows_d = bus.num_rows;
          count_d    = '0;
          state_d    = (bus.num_rows == '0) ? SEQ_DONE : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (in_xfer) begin
          count_d = count_q + CNT_ONE;
          if (row_last) state_d = SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        if (out_xfer && out_last) state_d = SEQ_DONE;
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
    busy_d   = (state_d == SEQ_RUN) || (state_d == SEQ_DRAIN);
    done_d   = (state_d == SEQ_DONE);
    act_en_d = (state_d == SEQ_RUN);
  end

  // Sequencer state; a reset mid-job drops everything with no done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      act_sel_q  <= ACT_PASS;
      num_rows_q <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      act_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_sel_q  <= act_sel_d;
      num_rows_q <= num_rows_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      act_en_q   <= act_en_d;
    end
  end

  act_pipe_reg u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (in_xfer),
    .load_row  (result_row),
    .load_last (row_last),
    .out_ready (bus.out_ready),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_last  (out_last)
  );

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.act_en    = act_en_q;
  assign bus.act_sel   = act_sel_q;
  // Operands are zeroed outside RUN so the activation units sit at zero
  assign bus.act_in    = act_en_q ? bus.in_row : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_row   = out_row;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_activation_sequencer.sv
// tb/tb_activation_sequencer.sv - scoreboard bench for activation_sequencer
module tb_activation_sequencer;
  import act_pkg::*;

  typedef struct {
    act_row_t row;
    logic     last;
  } exp_t;

  localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] NEG_MAX = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   in_xfers;
  int   out_xfers;
  int   job_rows;
  logic [1:0] job_func;
  exp_t exp_q[$];
  act_row_t act_stub;

  activation_sequencer_if bus();

  activation_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activation mux stand-in: every element plus one
  always_comb begin
    act_stub = '0;
    for (int i = 0; i < SA_LENGTH; i++) act_stub[i] = bus.act_in[i] + ONE;
  end
  assign bus.act_out = act_stub;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic act_row_t gen_row();
    act_row_t r;
    logic [31:0] t;
    for (int i = 0; i < SA_LENGTH; i++) begin
      t = $urandom;
      r[i] = t[DATA_WIDTH-1:0];
    end
    if (job_func == 2'd0) r[0] = NEG_MAX;
    return r;
  endfunction

  function automatic act_row_t model(input act_row_t r, input logic [1:0] f);
    act_row_t m;
    for (int i = 0; i < SA_LENGTH; i++) m[i] = (f == 2'd0) ? r[i] : r[i] + ONE;
    return m;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_output observed=%0h expected=none", bus.out_row[0]);
        end else begin
          e = exp_q.pop_front();
          checks++;
          assert (bus.out_row === e.row) else begin
            failures++;
            $error("FAIL out_row observed=%0h expected=%0h (element 0)", bus.out_row[0], e.row[0]);
          end
          chk("out_last", bus.out_last, e.last);
        end
        out_xfers++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.row  = model(bus.in_row, job_func);
        e.last = ((in_xfers + 1) == job_rows);
        exp_q.push_back(e);
        in_xfers++;
      end
    end
  end

  task automatic start_job(input logic [1:0] f, input int n);
    job_func  = f;
    job_rows  = n;
    in_xfers  = 0;
    out_xfers = 0;
    bus.func     = f;
    bus.num_rows = 9'(n);
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, (n != 0));
    chk("start_act_sel", bus.act_sel, f);
    chk("start_in_ready", bus.in_ready, (n != 0));
  endtask

  task automatic send_until(input int target, output int cycles);
    int seen;
    cycles = 0;
    bus.in_valid = 1'b1;
    bus.in_row   = gen_row();
    seen = in_xfers;
    while (in_xfers < target && cycles < 200) begin
      tick();
      cycles++;
      if (in_xfers != seen) begin
        seen = in_xfers;
        bus.in_row = gen_row();
      end
    end
    bus.in_valid = 1'b0;
    chk("send_count", in_xfers, target);
  endtask

  task automatic wait_done(input int exp_rows);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", bus.done, 1'b1);
    chk("done_busy", bus.busy, 1'b0);
    chk("done_out_count", out_xfers, exp_rows);
    chk("done_queue_empty", exp_q.size(), 0);
    tick();
    chk("done_one_cycle", bus.done, 1'b0);
  endtask

  initial begin
    int cyc;
    act_row_t snap;
    checks    = 0;
    failures  = 0;
    in_xfers  = 0;
    out_xfers = 0;
    job_rows  = 0;
    job_func  = 2'd0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.func     = 2'd0;
    bus.num_rows = '0;
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_out_row_zero", (bus.out_row === '0), 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_act_en", bus.act_en, 1'b0);
    chk("rst_act_sel", bus.act_sel, 2'd0);
    rst_n = 1'b1;
    tick();

    // Tanh, 4 rows streamed back to back
    start_job(2'd3, 4);
    chk("t1_act_en", bus.act_en, 1'b1);
    send_until(4, cyc);
    chk("t1_throughput", cyc, 4);
    chk("t1_drain_in_ready", bus.in_ready, 1'b0);
    chk("t1_drain_valid", bus.out_valid, 1'b1);
    chk("t1_drain_last", bus.out_last, 1'b1);
    chk("t1_drain_busy", bus.busy, 1'b1);
    tick();
    chk("t1_done", bus.done, 1'b1);
    chk("t1_busy_off", bus.busy, 1'b0);
    chk("t1_valid_off", bus.out_valid, 1'b0);
    chk("t1_act_en_off", bus.act_en, 1'b0);
    chk("t1_outs", out_xfers, 4);
    tick();
    chk("t1_done_pulse", bus.done, 1'b0);

    // Pass-through keeps -1024 regardless of act_out
    start_job(2'd0, 2);
    send_until(1, cyc);
    chk("t2_elem0", bus.out_row[0], NEG_MAX);
    chk("t2_act_sel", bus.act_sel, 2'd0);
    send_until(2, cyc);
    chk("t2_act_sel_end", bus.act_sel, 2'd0);
    wait_done(2);

    // Backpressure: 5 stalled cycles after the first output
    start_job(2'd1, 3);
    send_until(1, cyc);
    bus.out_ready = 1'b0;
    snap = bus.out_row;
    bus.in_valid = 1'b1;
    bus.in_row   = gen_row();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_stall_in_ready", bus.in_ready, 1'b0);
      chk("t3_stall_valid", bus.out_valid, 1'b1);
      chk("t3_stall_row", (bus.out_row === snap), 1'b1);
    end
    bus.out_ready = 1'b1;
    send_until(3, cyc);
    wait_done(3);

    // Empty job
    start_job(2'd2, 0);
    chk("t4_done", bus.done, 1'b1);
    chk("t4_out_valid", bus.out_valid, 1'b0);
    tick();
    chk("t4_done_pulse", bus.done, 1'b0);
    chk("t4_in_ready", bus.in_ready, 1'b0);

    // Start during RUN is ignored
    start_job(2'd2, 3);
    send_until(1, cyc);
    bus.func     = 2'd1;
    bus.num_rows = 9'd1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t5_act_sel", bus.act_sel, 2'd2);
    chk("t5_busy", bus.busy, 1'b1);
    send_until(3, cyc);
    wait_done(3);

    // Asynchronous reset after 2 of 5 rows
    start_job(2'd1, 5);
    send_until(2, cyc);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", bus.out_valid, 1'b0);
    chk("t6_out_row_zero", (bus.out_row === '0), 1'b1);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_act_en", bus.act_en, 1'b0);
    chk("t6_act_sel", bus.act_sel, 2'd0);
    chk("t6_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    tick();
    chk("t6_no_done", bus.done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("t6_idle_no_done", bus.done, 1'b0);
    start_job(2'd3, 2);
    send_until(2, cyc);
    wait_done(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/activation_sequencer.md
# activation_sequencer

Controller that streams systolic-array output rows through the shared combinational activation datapath (pass-through, ReLU, Sigmoid, Tanh) and hands results to the output buffer. For each job it latches the function select and a row count, then accepts rows over a valid/ready handshake. It drives the activation unit's enable, select and operands, registers the result in a one-stage pipeline, and signals completion. It sits between the accumulator drain port and the unified-buffer write port.

## Interface
- DATA_WIDTH, 11, element width (signed fixed point, S fraction bits handled inside the activation units)
- SA_LENGTH, 256, elements per row
- ROW_CNT_WIDTH, 9, width of the row counter and of num_rows
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  job start pulse; sampled only in IDLE
- func  in  2  activation select: 0 pass, 1 ReLU, 2 Sigmoid, 3 Tanh; latched on start
- num_rows  in  ROW_CNT_WIDTH  rows in job; latched on start
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at job end
- in_valid / in_ready  in / out  1 / 1  row input handshake
- in_row  in  DATA_WIDTH x SA_LENGTH  signed input row
- act_en  out  1  enable to activation units
- act_sel  out  2  latched func, routed to activation mux
- act_in  out  DATA_WIDTH x SA_LENGTH  operands to activation units
- act_out  in  DATA_WIDTH x SA_LENGTH  combinational result from activation mux
- out_valid / out_ready  out / in  1 / 1  row output handshake
- out_row  out  DATA_WIDTH x SA_LENGTH  registered result
- out_last  out  1  qualifies final row of job, valid with out_valid

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0, act_en=0. On start, latch func->act_sel and num_rows, clear row count.
  - If num_rows=0: go to DONE.
  - Otherwise: go to RUN.
- RUN:
  - in_ready = !out_valid || out_ready.
  - act_en=1; act_in=in_row.
  - On input transfer (in_valid && in_ready): out_row <= (act_sel==0) ? in_row : act_out; out_valid <= 1; count++; out_last <= (count+1 == num_rows).
  - After the transfer that makes count==num_rows: go to DRAIN; in_ready=0 from the next cycle.
- DRAIN: in_ready=0, act_en=0. On output transfer with out_last=1: clear out_valid and out_last, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Output register: out_valid clears on output transfer when no simultaneous input transfer. A simultaneous input and output transfer in RUN replaces out_row and keeps out_valid=1.
- act_en=0 in all states except RUN, so activation units output 0 when idle.
- start while busy or in DONE: ignored; func and num_rows changes mid-job have no effect.
- No arithmetic in this block; widths pass through unchanged. Count compares unsigned.

## Timing
- Reset values: out_valid=0, out_last=0, out_row=all 0, done=0, busy=0, in_ready=0, act_en=0, act_sel=0, state IDLE, count=0.
- Reset mid-job aborts immediately: no done pulse, pending out_row is discarded.
- Latency: start at edge N -> busy=1 and in_ready=1 (if out_valid=0) in cycle N+1.
- Input transfer at edge N -> out_valid=1 with the result in cycle N+1.
- Throughput: one row per cycle while out_ready is held high.
- Backpressure: out_valid && !out_ready forces in_ready=0. out_row is stable until the output transfer.
- Final output transfer at edge N -> done=1 in cycle N+1, busy=0 in cycle N+1, IDLE in cycle N+2. Earliest next start is accepted in cycle N+2.
- num_rows=0: start at edge N -> done=1 in cycle N+1, with no in_ready assertion.

## Structure
- Shared package act_pkg: act_func_e enum (ACT_PASS, ACT_RELU, ACT_SIGMOID, ACT_TANH), act_seq_state_e enum, SA_LENGTH and DATA_WIDTH defaults.
- Same act_func_e feeds the activation mux select, so encodings must match it.
- One sub-module: act_pipe_reg, the valid/ready single-stage row register with last flag.
- The FSM and row counter stay in activation_sequencer.

## Test plan
- func=3 (Tanh), num_rows=4, in_valid and out_ready high, act_out stubbed = in_row+1 -> four consecutive outputs one cycle after each input; out_last on the 4th only; done the cycle after the 4th output transfer.
- func=0, num_rows=2, in_row element 0 = -1024 -> out_row element 0 = -1024 regardless of act_out; act_sel=0 throughout.
- num_rows=3, out_ready low for 5 cycles after the first output -> in_ready=0 those cycles; out_row unchanged; all 3 rows delivered in order with no loss or duplication.
- num_rows=0 start -> done pulse next cycle; in_ready never high; out_valid never high.
- start asserted during RUN with func=1 -> ignored; act_sel keeps its original value; job completes with the original num_rows.
- rst_n low mid-job after 2 of 5 rows -> all outputs return to reset values asynchronously; no done pulse; a new job after reset runs normally.
